// File: rtl/perf_counter_bank_if.sv
// Bundle of event, trigger, config and readout signals for perf_counter_bank.
interface perf_counter_bank_if #(
    parameter int PERF_REG_NUM = 4,
    parameter int CNT_WIDTH    = 32,
    parameter int EVT_NUM      = 8
);
    localparam int EVT_SEL_W = (EVT_NUM > 1) ? $clog2(EVT_NUM) : 1;
    localparam int IDX_W     = (PERF_REG_NUM > 1) ? $clog2(PERF_REG_NUM) : 1;

    logic [EVT_NUM-1:0]                        events;
    logic                                      clear_trigger;
    logic                                      toggle_trigger;
    logic                                      snap_trigger;
    logic                                      cfg_we;
    logic [IDX_W-1:0]                          cfg_idx;
    logic [EVT_SEL_W-1:0]                      cfg_evt_sel;
    logic                                      cfg_sat;
    logic [PERF_REG_NUM-1:0][CNT_WIDTH-1:0]    counter_r;
    logic [PERF_REG_NUM-1:0][CNT_WIDTH-1:0]    snapshot_r;
    logic [PERF_REG_NUM-1:0]                   overflow_r;
    logic                                      enabled_r;

    modport master (
        output events, clear_trigger, toggle_trigger, snap_trigger,
        output cfg_we, cfg_idx, cfg_evt_sel, cfg_sat,
        input  counter_r, snapshot_r, overflow_r, enabled_r
    );

    modport slave (
        input  events, clear_trigger, toggle_trigger, snap_trigger,
        input  cfg_we, cfg_idx, cfg_evt_sel, cfg_sat,
        output counter_r, snapshot_r, overflow_r, enabled_r
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Bank of selectable event counters with wrap/saturate overflow, sticky
// overflow flags and an atomic snapshot / read-and-clear capture.
module perf_counter_lane #(
    parameter int CNT_WIDTH = 32,
    parameter int EVT_NUM   = 8,
    parameter int EVT_SEL_W = 3,
    parameter int LANE      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clear,
    input  logic                 snap,
    input  logic                 cfg_wr,
    input  logic [EVT_SEL_W-1:0] cfg_evt_sel,
    input  logic                 cfg_sat,
    input  logic [EVT_NUM-1:0]   events,
    output logic [CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0] snapshot,
    output logic                 overflow
);
    localparam logic [EVT_SEL_W-1:0] SEL_RST = EVT_SEL_W'(LANE % EVT_NUM);

    logic [EVT_SEL_W-1:0] sel;
    logic                 sat;
    logic                 hit;

    // Selects past the last event input never match, so they never count.
    always_comb begin
        hit = 1'b0;
        for (int j = 0; j < EVT_NUM; j++) begin
            if (sel == EVT_SEL_W'(j)) hit = events[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            snapshot <= '0;
            overflow <= 1'b0;
            sel      <= SEL_RST;
            sat      <= 1'b0;
        end else begin
            if (snap) snapshot <= count;
            if (cfg_wr) begin
                sel <= cfg_evt_sel;
                sat <= cfg_sat;
            end
            if (clear) begin
                count    <= '0;
                overflow <= 1'b0;
            end else if (en && hit) begin
                if (&count) begin
                    overflow <= 1'b1;
                    if (!sat) count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end
endmodule

module perf_counter_bank #(
    parameter int PERF_REG_NUM = 4,
    parameter int CNT_WIDTH    = 32,
    parameter int EVT_NUM      = 8
) (
    input logic              clk,
    input logic              rst,
    perf_counter_bank_if.slave bus
);
    localparam int EVT_SEL_W = (EVT_NUM > 1) ? $clog2(EVT_NUM) : 1;
    localparam int IDX_W     = (PERF_REG_NUM > 1) ? $clog2(PERF_REG_NUM) : 1;

    logic [PERF_REG_NUM-1:0][CNT_WIDTH-1:0] cnt;
    logic [PERF_REG_NUM-1:0][CNT_WIDTH-1:0] snp;
    logic [PERF_REG_NUM-1:0]                ovf;
    logic                                   en;

    always_ff @(posedge clk) begin
        if (rst)                     en <= 1'b0;
        else if (bus.toggle_trigger) en <= ~en;
    end

    // Out-of-range cfg_idx matches no lane, so the write is dropped.
    for (genvar i = 0; i < PERF_REG_NUM; i++) begin : g_lane
        perf_counter_lane #(
            .CNT_WIDTH (CNT_WIDTH),
            .EVT_NUM   (EVT_NUM),
            .EVT_SEL_W (EVT_SEL_W),
            .LANE      (i)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .en          (en),
            .clear       (bus.clear_trigger),
            .snap        (bus.snap_trigger),
            .cfg_wr      (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))),
            .cfg_evt_sel (bus.cfg_evt_sel),
            .cfg_sat     (bus.cfg_sat),
            .events      (bus.events),
            .count       (cnt[i]),
            .snapshot    (snp[i]),
            .overflow    (ovf[i])
        );
    end

    assign bus.counter_r  = cnt;
    assign bus.snapshot_r = snp;
    assign bus.overflow_r = ovf;
    assign bus.enabled_r  = en;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboarded bench: directed scenarios plus random traffic against an
// integer-level model of the counter bank.
module tb_perf_counter_bank;
    localparam int NUM = 3;
    localparam int CW  = 4;
    localparam int EVT = 6;
    localparam int MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    perf_counter_bank_if #(.PERF_REG_NUM(NUM), .CNT_WIDTH(CW), .EVT_NUM(EVT)) bus ();

    perf_counter_bank #(.PERF_REG_NUM(NUM), .CNT_WIDTH(CW), .EVT_NUM(EVT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NUM-1:0][CW-1:0] cnt;
        logic [NUM-1:0][CW-1:0] snap;
        logic [NUM-1:0]         ovf;
        logic                   en;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int m_cnt[NUM];
    int m_snap[NUM];
    int m_sel[NUM];
    bit m_ovf[NUM];
    bit m_sat[NUM];
    bit m_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM; i++) begin
            m_cnt[i]  = 0;
            m_snap[i] = 0;
            m_ovf[i]  = 0;
            m_sel[i]  = i % EVT;
            m_sat[i]  = 0;
        end
        m_en = 0;
    endfunction

    // Advance the model by one clock using the inputs now on the bus, queue
    // the expected post-edge state, then wait for the next falling edge.
    task automatic step();
        exp_t e;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NUM; i++) begin
                bit fire;
                fire = 0;
                if (bus.snap_trigger) m_snap[i] = m_cnt[i];
                if (m_en && m_sel[i] < EVT) fire = bus.events[m_sel[i]];
                if (bus.clear_trigger) begin
                    m_cnt[i] = 0;
                    m_ovf[i] = 0;
                end else if (fire) begin
                    if (m_cnt[i] == MAX) begin
                        m_ovf[i] = 1;
                        m_cnt[i] = m_sat[i] ? MAX : 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
            if (bus.cfg_we && int'(bus.cfg_idx) < NUM) begin
                m_sel[bus.cfg_idx] = int'(bus.cfg_evt_sel);
                m_sat[bus.cfg_idx] = bus.cfg_sat;
            end
            if (bus.toggle_trigger) m_en = !m_en;
        end
        for (int i = 0; i < NUM; i++) begin
            e.cnt[i]  = CW'(m_cnt[i]);
            e.snap[i] = CW'(m_snap[i]);
            e.ovf[i]  = m_ovf[i];
        end
        e.en = m_en;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic cyc(input logic [EVT-1:0] ev, input bit clr = 0, input bit tog = 0,
                       input bit snp = 0);
        bus.events         = ev;
        bus.clear_trigger  = clr;
        bus.toggle_trigger = tog;
        bus.snap_trigger   = snp;
        step();
        bus.events         = '0;
        bus.clear_trigger  = 1'b0;
        bus.toggle_trigger = 1'b0;
        bus.snap_trigger   = 1'b0;
        bus.cfg_we         = 1'b0;
    endtask

    task automatic cfg(input int idx, input int sel, input bit sat);
        bus.cfg_we      = 1'b1;
        bus.cfg_idx     = 2'(idx);
        bus.cfg_evt_sel = 3'(sel);
        bus.cfg_sat     = sat;
    endtask

    // Monitor: every expectation is popped one time unit after the edge it describes.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i < NUM; i++) begin
                chk($sformatf("counter_r[%0d]", i), 64'(bus.counter_r[i]), 64'(e.cnt[i]));
                chk($sformatf("snapshot_r[%0d]", i), 64'(bus.snapshot_r[i]), 64'(e.snap[i]));
                chk($sformatf("overflow_r[%0d]", i), 64'(bus.overflow_r[i]), 64'(e.ovf[i]));
            end
            chk("enabled_r", 64'(bus.enabled_r), 64'(e.en));
        end
    end

    initial begin
        rst                = 1'b1;
        bus.events         = '0;
        bus.clear_trigger  = 1'b0;
        bus.toggle_trigger = 1'b0;
        bus.snap_trigger   = 1'b0;
        bus.cfg_we         = 1'b0;
        bus.cfg_idx        = '0;
        bus.cfg_evt_sel    = '0;
        bus.cfg_sat        = 1'b0;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        chk("reset enabled", 64'(bus.enabled_r), 64'd0);
        chk("reset counter0", 64'(bus.counter_r[0]), 64'd0);

        // Enable then five events on counter 0.
        cyc('0, 0, 1);
        repeat (5) cyc(6'b000001);
        chk("basic c0", 64'(bus.counter_r[0]), 64'd5);
        chk("basic c1", 64'(bus.counter_r[1]), 64'd0);
        chk("basic en", 64'(bus.enabled_r), 64'd1);

        // Wrap mode: 17 events on a 4-bit counter.
        cyc('0, 1);
        repeat (17) cyc(6'b000001);
        chk("wrap c0", 64'(bus.counter_r[0]), 64'd1);
        chk("wrap ovf0", 64'(bus.overflow_r[0]), 64'd1);

        // Saturate mode.
        cfg(0, 0, 1);
        cyc('0, 1);
        repeat (17) cyc(6'b000001);
        chk("sat c0", 64'(bus.counter_r[0]), 64'd15);
        chk("sat ovf0", 64'(bus.overflow_r[0]), 64'd1);

        // Atomic read-and-clear with an event present.
        cfg(0, 0, 0);
        cyc('0, 1);
        repeat (9) cyc(6'b000001);
        cyc(6'b000001, 1, 0, 1);
        chk("rdclr snap0", 64'(bus.snapshot_r[0]), 64'd9);
        chk("rdclr c0", 64'(bus.counter_r[0]), 64'd0);
        chk("rdclr ovf0", 64'(bus.overflow_r[0]), 64'd0);

        // Coincident cfg write uses the old select.
        cyc('0, 1);
        cfg(1, 3, 0);
        cyc(6'b000010);
        cyc(6'b000010);
        cyc(6'b001000);
        chk("cfg c1", 64'(bus.counter_r[1]), 64'd2);

        // Out-of-range index ignored; out-of-range select never counts.
        cfg(3, 0, 1);
        cyc('0);
        cfg(2, 6, 0);
        cyc('0, 1);
        repeat (3) cyc('1);
        chk("badsel c2", 64'(bus.counter_r[2]), 64'd0);
        chk("badidx c0", 64'(bus.counter_r[0]), 64'd3);

        // Toggle and clear together while enabled.
        cyc('1, 1, 1);
        repeat (3) cyc('1);
        chk("togclr c0", 64'(bus.counter_r[0]), 64'd0);
        chk("togclr en", 64'(bus.enabled_r), 64'd0);

        // Reset mid-count restores selects.
        cyc('0, 0, 1);
        repeat (4) cyc('1);
        rst = 1'b1;
        cyc('1);
        rst = 1'b0;
        chk("rst c1", 64'(bus.counter_r[1]), 64'd0);
        chk("rst en", 64'(bus.enabled_r), 64'd0);
        cyc('0, 0, 1);
        cyc(6'b000010);
        chk("rst sel1", 64'(bus.counter_r[1]), 64'd1);

        repeat (800) begin
            rst                = ($urandom_range(0, 149) == 0);
            bus.events         = EVT'($urandom);
            bus.clear_trigger  = ($urandom_range(0, 59) == 0);
            bus.toggle_trigger = ($urandom_range(0, 11) == 0);
            bus.snap_trigger   = ($urandom_range(0, 4) == 0);
            bus.cfg_we         = ($urandom_range(0, 7) == 0);
            bus.cfg_idx        = 2'($urandom);
            bus.cfg_evt_sel    = 3'($urandom);
            bus.cfg_sat        = 1'($urandom);
            step();
        end
        rst = 1'b0;
        cyc('0);

        chk("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
